// File: rtl/phy_tx_ms_if.sv
// SIE-side handshake and pad-driver signals of the phy_tx_ms transmitter.
interface phy_tx_ms_if;
    logic       ls_mode_i;
    logic       tx_valid_i;
    logic [7:0] tx_data_i;
    logic       tx_ready_o;
    logic       tx_en_o;
    logic       tx_dp_o;
    logic       tx_dn_o;
    logic       busy_o;

    modport master (
        output ls_mode_i, tx_valid_i, tx_data_i,
        input  tx_ready_o, tx_en_o, tx_dp_o, tx_dn_o, busy_o
    );
    modport slave (
        input  ls_mode_i, tx_valid_i, tx_data_i,
        output tx_ready_o, tx_en_o, tx_dp_o, tx_dn_o, busy_o
    );
endinterface

// File: rtl/phy_tx_ms.sv
// USB 2.0 FS/LS transmit PHY: SYNC, NRZI, bit stuffing and EOP generation.
// Define PHY_TX_RESUME_EN to add the resume_i K-drive (resume signalling) path.
module phy_tx_ms #(
    parameter int BIT_SAMPLES  = 4,
    parameter int LS_RATIO     = 8,
    parameter int SYNC_BITS    = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
`ifdef PHY_TX_RESUME_EN
    input  logic       resume_i,
`endif
    phy_tx_ms_if.slave tx
);
    localparam int P_FS = BIT_SAMPLES;
    localparam int P_LS = BIT_SAMPLES * LS_RATIO;
    localparam int CW   = $clog2(P_LS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SYNC    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STUFF   = 3'd3;
    localparam logic [2:0] S_EOP_SE0 = 3'd4;
    localparam logic [2:0] S_EOP_J   = 3'd5;
`ifdef PHY_TX_RESUME_EN
    localparam logic [2:0] S_RES_K   = 3'd6;
    localparam logic [2:0] S_RES_SE0 = 3'd7;
`endif

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bcnt_q, bcnt_d;   // SYNC bit, data bit or EOP bit index
    logic          ls_q, ls_d;
    logic [7:0]    byte_q, byte_d;
    logic [2:0]    ones_q, ones_d;
    logic          lvl_q, lvl_d;     // NRZI line level, 1 = J
    logic [CW-1:0] per_m1;
    logic          bit_end, ready, emit, nxt_bit, se0, lvl_out;

    assign per_m1  = ls_q ? CW'(P_LS - 1) : CW'(P_FS - 1);
    assign bit_end = (cnt_q == per_m1);
`ifdef PHY_TX_RESUME_EN
    logic ls_end;
    // Resume SE0 is always timed in low-speed bit periods.
    assign ls_end = (cnt_q == CW'(P_LS - 1));
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        bcnt_d  = bcnt_q;
        ls_d    = ls_q;
        byte_d  = byte_q;
        ones_d  = ones_q;
        lvl_d   = lvl_q;
        ready   = 1'b0;
        emit    = 1'b0;
        nxt_bit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx.tx_valid_i) begin
                    if (cnt_q == '0) ls_d = tx.ls_mode_i;
                    if (bit_end) begin
                        state_d = S_SYNC;
                        bcnt_d  = '0;
                        emit    = 1'b1;
                    end
                end else begin
                    cnt_d = '0;
`ifdef PHY_TX_RESUME_EN
                    if (resume_i) state_d = S_RES_K;
`endif
                end
            end
            S_SYNC: if (bit_end) begin
                if (bcnt_q == 5'(SYNC_BITS - 1)) begin
                    if (tx.tx_valid_i) begin
                        ready   = 1'b1;
                        byte_d  = tx.tx_data_i;
                        bcnt_d  = '0;
                        state_d = S_DATA;
                        emit    = 1'b1;
                        nxt_bit = tx.tx_data_i[0];
                    end else begin
                        state_d = S_IDLE;
                        lvl_d   = 1'b1;
                        ones_d  = '0;
                    end
                end else begin
                    bcnt_d  = bcnt_q + 5'd1;
                    emit    = 1'b1;
                    nxt_bit = (bcnt_q == 5'(SYNC_BITS - 2));
                end
            end
            S_DATA, S_STUFF: if (bit_end) begin
                // A pending stuff bit always goes out before the next data bit or EOP.
                if (state_q == S_DATA && ones_q == 3'(STUFF_LEN)) begin
                    state_d = S_STUFF;
                    emit    = 1'b1;
                end else if (bcnt_q[2:0] != 3'd7) begin
                    state_d = S_DATA;
                    bcnt_d  = bcnt_q + 5'd1;
                    emit    = 1'b1;
                    nxt_bit = byte_q[bcnt_q[2:0] + 3'd1];
                end else if (tx.tx_valid_i) begin
                    ready   = 1'b1;
                    byte_d  = tx.tx_data_i;
                    bcnt_d  = '0;
                    state_d = S_DATA;
                    emit    = 1'b1;
                    nxt_bit = tx.tx_data_i[0];
                end else begin
                    state_d = S_EOP_SE0;
                    bcnt_d  = '0;
                    ones_d  = '0;
                end
            end
            S_EOP_SE0: if (bit_end) begin
                if (bcnt_q == 5'(EOP_SE0_BITS - 1)) begin
                    state_d = S_EOP_J;
                    lvl_d   = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 5'd1;
                end
            end
            S_EOP_J: if (bit_end) state_d = S_IDLE;
`ifdef PHY_TX_RESUME_EN
            S_RES_K: begin
                cnt_d = '0;
                if (!resume_i) begin
                    state_d = S_RES_SE0;
                    bcnt_d  = '0;
                end
            end
            S_RES_SE0: begin
                cnt_d = ls_end ? '0 : cnt_q + CW'(1);
                if (ls_end) begin
                    if (bcnt_q == 5'd1) begin
                        state_d = S_EOP_J;
                        lvl_d   = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // NRZI: a zero toggles the line, a one holds it and feeds the stuff counter.
        if (emit) begin
            lvl_d  = nxt_bit ? lvl_q : ~lvl_q;
            ones_d = nxt_bit ? ones_q + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            ls_q    <= 1'b0;
            byte_q  <= '0;
            ones_q  <= '0;
            lvl_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            ls_q    <= ls_d;
            byte_q  <= byte_d;
            ones_q  <= ones_d;
            lvl_q   <= lvl_d;
        end
    end

    always_comb begin
        se0     = (state_q == S_EOP_SE0);
        lvl_out = lvl_q;
`ifdef PHY_TX_RESUME_EN
        if (state_q == S_RES_SE0) se0 = 1'b1;
        if (state_q == S_RES_K) lvl_out = 1'b0;
`endif
    end

    // J is (1,0) at full speed and (0,1) at low speed.
    assign tx.tx_dp_o    = ~se0 & (lvl_out ^ ls_q);
    assign tx.tx_dn_o    = ~se0 & ~(lvl_out ^ ls_q);
    assign tx.tx_en_o    = (state_q != S_IDLE);
    assign tx.busy_o     = (state_q != S_IDLE);
    assign tx.tx_ready_o = ready & ~rst_i;
endmodule

// File: tb/tb_phy_tx_ms.sv
// Randomized bench for phy_tx_ms: a bit-list packet model expanded to per-clock
// expectations on {tx_en, dp, dn, ready, busy} for two parameter sets.
module tb_phy_tx_ms;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
`ifdef PHY_TX_RESUME_EN
  logic resume0 = 1'b0;
  logic resume1 = 1'b0;
`endif

  phy_tx_ms_if if0();
  phy_tx_ms_if if1();

  phy_tx_ms #(.BIT_SAMPLES(4), .LS_RATIO(8), .SYNC_BITS(8), .STUFF_LEN(6), .EOP_SE0_BITS(2)) dut0 (
    .clk_i(clk),
    .rst_i(rst),
`ifdef PHY_TX_RESUME_EN
    .resume_i(resume0),
`endif
    .tx(if0.slave)
  );
  phy_tx_ms #(.BIT_SAMPLES(4), .LS_RATIO(8), .SYNC_BITS(32), .STUFF_LEN(7), .EOP_SE0_BITS(3)) dut1 (
    .clk_i(clk),
    .rst_i(rst),
`ifdef PHY_TX_RESUME_EN
    .resume_i(resume1),
`endif
    .tx(if1.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] pkt[$];
  logic [4:0] exp_q[$];   // {en, dp, dn, ready, busy}
  bit prev_ls[2] = '{1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply(input int sel, input bit v, input logic [7:0] d, input bit ls);
    if (sel == 0) begin
      if0.tx_valid_i = v; if0.tx_data_i = d; if0.ls_mode_i = ls;
    end else begin
      if1.tx_valid_i = v; if1.tx_data_i = d; if1.ls_mode_i = ls;
    end
  endtask

  function automatic logic [4:0] sample(input int sel);
    if (sel == 0) return {if0.tx_en_o, if0.tx_dp_o, if0.tx_dn_o, if0.tx_ready_o, if0.busy_o};
    return {if1.tx_en_o, if1.tx_dp_o, if1.tx_dn_o, if1.tx_ready_o, if1.busy_o};
  endfunction

  // Packet as a list of line symbols (0/1 data, 2 = SE0, 3 = J), then per-clock expansion.
  task automatic build_exp(input int sel, input bit ls, input bit pls, input int nb);
    int sym[$];
    bit rdy[$];
    int ones, p, sb, sl, eb;
    bit lvl, b, d;
    sb = (sel == 1) ? 32 : 8;
    sl = (sel == 1) ? 7 : 6;
    eb = (sel == 1) ? 3 : 2;
    exp_q.delete();
    for (int i = 0; i < sb; i++) begin sym.push_back((i == sb - 1) ? 1 : 0); rdy.push_back(1'b0); end
    ones = 1;
    for (int k = 0; k < nb; k++) begin
      rdy[rdy.size() - 1] = 1'b1;
      for (int j = 0; j < 8; j++) begin
        b = pkt[k][j];
        sym.push_back(b ? 1 : 0); rdy.push_back(1'b0);
        if (b) begin
          ones++;
          if (ones == sl) begin sym.push_back(0); rdy.push_back(1'b0); ones = 0; end
        end else ones = 0;
      end
    end
    if (nb > 0) begin
      for (int i = 0; i < eb; i++) begin sym.push_back(2); rdy.push_back(1'b0); end
      sym.push_back(3); rdy.push_back(1'b0);
    end
    p = ls ? 32 : 4;
    for (int c = 0; c < p; c++) begin
      d = (c == 0) ? pls : ls;
      exp_q.push_back({1'b0, ~d, d, 1'b0, 1'b0});
    end
    lvl = 1'b1;
    foreach (sym[i]) begin
      if (sym[i] == 0) lvl = ~lvl;
      if (sym[i] == 3) lvl = 1'b1;
      for (int c = 0; c < p; c++) begin
        if (sym[i] == 2) exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        else exp_q.push_back({1'b1, lvl ^ ls, ~(lvl ^ ls), rdy[i] && (c == p - 1), 1'b1});
      end
    end
    for (int c = 0; c < 2 * p; c++) exp_q.push_back({1'b0, ~ls, ls, 1'b0, 1'b0});
  endtask

  // Starts just after a rising edge; drives bytes on each ready pulse.
  task automatic run_pkt(input int sel, input bit ls, input int nb, input int drop_at,
                         input int stop_at, input bit wiggle);
    int idx, nrdy;
    bit adv, cv, cls;
    logic [7:0] cd;
    logic [4:0] o;
    idx = 0; nrdy = 0;
    build_exp(sel, ls, prev_ls[sel], nb);
    cv = 1'b1; cd = pkt[0]; cls = ls;
    apply(sel, cv, cd, cls);
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      o = sample(sel);
      chk($sformatf("dut%0d_cyc%0d", sel, c), {27'd0, o}, {27'd0, exp_q[c]});
      adv = o[1];
      if (adv) nrdy++;
      if (c == stop_at) return;
      @(posedge clk); #1;
      if (adv) begin
        idx++;
        if (idx < nb) cd = pkt[idx]; else cv = 1'b0;
      end
      if (c == drop_at) cv = 1'b0;
      if (wiggle && (c % 23 == 5)) cls = ~cls;
      apply(sel, cv, cd, cls);
    end
    chk($sformatf("dut%0d_ready_count", sel), nrdy, nb);
    prev_ls[sel] = ls;
  endtask

  initial begin
    apply(0, 1'b0, 8'h00, 1'b0);
    apply(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_dut0", {27'd0, sample(0)}, 32'b01000);
    chk("reset_dut1", {27'd0, sample(1)}, 32'b01000);
    @(posedge clk); #1;

    pkt.delete(); pkt.push_back(8'h80);
    run_pkt(0, 1'b0, 1, -1, -1, 1'b0);
    pkt.delete(); pkt.push_back(8'hFF); pkt.push_back(8'h01);
    run_pkt(0, 1'b0, 2, -1, -1, 1'b0);
    pkt.delete(); pkt.push_back(8'h00);
    run_pkt(0, 1'b1, 1, -1, -1, 1'b1);
    pkt.delete(); pkt.push_back(8'hFF); pkt.push_back(8'hFF);
    run_pkt(1, 1'b0, 2, -1, -1, 1'b0);
    pkt.delete(); pkt.push_back(8'h5A);
    run_pkt(0, 1'b0, 0, 8, -1, 1'b0);
    run_pkt(1, 1'b1, 0, 40, -1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      int rsel, rnb;
      bit rls;
      rsel = $urandom_range(0, 1);
      rls  = ($urandom_range(0, 3) == 0);
      rnb  = $urandom_range(1, 3);
      pkt.delete();
      for (int k = 0; k < rnb; k++) pkt.push_back(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
      run_pkt(rsel, rls, rnb, -1, -1, ($urandom_range(0, 1) == 1));
    end

    // Reset in the middle of the first data byte.
    pkt.delete(); pkt.push_back(8'hFF); pkt.push_back(8'hFF);
    run_pkt(0, 1'b0, 2, -1, 50, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    apply(0, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("midpkt_reset", {27'd0, sample(0)}, 32'b01000);
    @(posedge clk); #1;
    rst = 1'b0;
    prev_ls[0] = 1'b0; prev_ls[1] = 1'b0;
    pkt.delete(); pkt.push_back(8'h3C);
    run_pkt(0, 1'b0, 1, -1, -1, 1'b0);

`ifdef PHY_TX_RESUME_EN
    resume0 = 1'b1;
    for (int c = 0; c < 176; c++) begin
      logic [4:0] e;
      @(negedge clk);
      if (c >= 1 && c <= 100) e = 5'b10101;
      else if (c >= 101 && c <= 164) e = 5'b10001;
      else if (c >= 165 && c <= 168) e = 5'b11001;
      else e = 5'b01000;
      chk($sformatf("resume_cyc%0d", c), {27'd0, sample(0)}, {27'd0, e});
      @(posedge clk); #1;
      if (c == 99) resume0 = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
